// File: rtl/ofifo_col_if.sv
// ofifo_col_if
//   Groups the data/handshake signals of the column output FIFO.
//   master : array/downstream side (drives in, wr, rd; observes out and flags)
//   slave  : the FIFO itself
//   in          column psums, lane i = in[psum_bw*(i+1)-1 -: psum_bw]
//   wr          per-lane write strobes
//   rd          pop one full row
//   out         head entry of every lane (same packing as in)
//   o_valid     every lane non-empty
//   o_full      at least one lane full
//   o_overflow  sticky, a write was dropped
//   o_underflow sticky, rd while not valid
interface ofifo_col_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_overflow, o_underflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_overflow, o_underflow
    );
endinterface

// File: rtl/ofifo_col.sv
// ofifo_col
//   Output FIFO collecting partial sums from the bottom of the MAC array.
//   One independent lane per column, written by its own strobe; rows are
//   popped in lock-step across all lanes. Show-ahead output.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears pointers and sticky flags)
//   bus    ofifo_col_if.slave (in, wr, rd, out, o_valid, o_full,
//          o_overflow, o_underflow)
module ofifo_col #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input logic        clk,
    input logic        reset,
    ofifo_col_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    // All lanes pop together and reset together, so their read pointers are
    // always identical; a single shared read pointer represents all of them.
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q [col];
    logic [PW-1:0]      wr_ptr_d [col];
    logic [psum_bw-1:0] mem_q    [col][depth];

    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [col-1:0]     lane_empty;
    logic [col-1:0]     lane_full;
    logic [col-1:0]     accept;
    logic               valid;
    logic               pop;
    logic               drop;

    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        for (int unsigned i = 0; i < col; i++) begin
            lane_empty[i] = (wr_ptr_q[i] == rd_ptr_q);
            lane_full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[AW-1:0]) &&
                            (wr_ptr_q[i][AW] != rd_ptr_q[AW]);
        end
    end

    assign valid = ~|lane_empty;
    assign pop   = bus.rd & valid;
    // A pop frees one slot in every lane, so a full lane may still accept.
    assign accept = bus.wr & (~lane_full | {col{pop}});
    assign drop   = (|(bus.wr & lane_full)) & ~pop;

    always_comb begin
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        overflow_d  = overflow_q | drop;
        underflow_d = underflow_q | (bus.rd & ~valid);
        for (int unsigned i = 0; i < col; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(accept[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= '0;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
            end
        end
    end

    // Storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < col; i++) begin
            if (reset && accept[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.in[i*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        bus.out = '0;
        for (int unsigned i = 0; i < col; i++) begin
            bus.out[i*psum_bw +: psum_bw] = mem_q[i][rd_ptr_q[AW-1:0]];
        end
    end

    assign bus.o_valid     = valid;
    assign bus.o_full      = |lane_full;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule
